jpeg_stream_quantizer: RTL
==========================

Name: jpeg_stream_quantizer

Overview:
Parametrised, coefficient-serial successor to the fixed 8x8 luma quantizer. It accepts DCT coefficients one per cycle in block order (64 per block) over a valid/ready stream. Each coefficient is multiplied by a per-position reciprocal taken from one of NUM_TABLES runtime-programmable tables (luma, chroma, ...), rounded to nearest and saturated. It sits between the DCT stage and the zigzag/entropy stage, and handles all channels through one instance.

Parameters:
IN_W, 11, signed input coefficient width
OUT_W, 11, signed output coefficient width (saturating)
FRAC, 12, reciprocal fraction bits; R = round(2^FRAC / q)
R_W, 13, unsigned reciprocal width (must hold 2^FRAC)
NUM_TABLES, 2, number of reciprocal tables (0 = luma, 1 = chroma)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  coefficient valid
in_ready  out  1  block can accept a coefficient this cycle
in_data  in  IN_W  signed DCT coefficient
in_tsel  in  $clog2(NUM_TABLES)  table select, sampled on the first coefficient of a block only
out_valid  out  1  quantized coefficient valid
out_ready  in  1  downstream accepts
out_data  out  OUT_W  signed quantized coefficient
out_idx  out  6  position 0..63 of out_data within its block
out_last  out  1  high with idx 63
cfg_we  in  1  table write strobe
cfg_table  in  $clog2(NUM_TABLES)  table being written
cfg_addr  in  6  position 0..63
cfg_data  in  R_W  reciprocal value
cfg_err  out  1  one-cycle pulse: write rejected
busy  out  1  block in progress or pipeline non-empty

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (rst): all valid flags, idx counter, cfg_err and busy go to 0. out_data, out_idx and out_last go to 0. Every table entry goes to 2^FRAC, so the default table is the identity.
- Input transfer happens when in_valid && in_ready. The output transfer happens when out_valid && out_ready.
- Pipeline has 2 stages:
  - S1 registers the coefficient, its idx and the table entry R.
  - S2 registers the result.
  - Latency is 2 cycles from accept to out_valid when there is no stall.
- Stall: when out_valid && !out_ready, both stages hold and in_ready = 0. Otherwise in_ready = 1. No data may be lost or duplicated under any ready pattern. out_data, out_idx and out_last stay stable while stalled.
- Block FSM has two states, IDLE (idx==0) and IN_BLOCK (idx 1..63). The idx counter increments on each accepted input and wraps 63 -> 0, returning to IDLE.
- On an accept in IDLE, in_tsel is latched as the active table. in_tsel is ignored in IN_BLOCK, so changing it mid-block has no effect.
- in_tsel >= NUM_TABLES selects table 0.
- Arithmetic:
  - P = in_data * R, a signed product (R is zero-extended) of width IN_W+R_W+1.
  - Rounding: Q = (P + 2^(FRAC-1)) >>> FRAC, which is round-half-up toward +inf.
  - Q is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - R = 0 yields 0.
- Config writes:
  - A write is accepted only when busy == 0 and in_valid == 0. It updates the table entry at the next clock edge.
  - Otherwise the write is dropped and cfg_err pulses for 1 cycle.
  - Out-of-range cfg_table also drops the write and pulses cfg_err.
- busy = (state == IN_BLOCK) || S1 valid || S2 valid.
- rst asserted mid-block aborts the block: pipeline contents are discarded and idx returns to 0. Tables are also re-initialised to identity.
- Back-to-back blocks are supported with no bubble: idx 63 is followed by idx 0 of the next block, and in_tsel is re-sampled at that point.

Test Plan:
1. Reset, default tables, ramp 0..63 streamed with out_ready = 1 -> out_data equals input for each coefficient, out_idx 0..63, out_last only at 63, first out_valid 2 cycles after the first accept.
2. Program table 1 with R = 256 at all positions (q = 16), block with in_tsel = 1 -> outputs: 100 -> 6, -40 -> -2 (a -2.5 tie rounds up), 24 -> 2 (1.5 rounds to 2), 1023 -> 64, -1024 -> -64.
3. OUT_W = 8, identity table: inputs 1023, -1024, 127, -128 -> outputs 127, -128, 127, -128 (saturation).
4. Random out_ready toggling (~50%) over 3 back-to-back blocks using in_tsel 0, 1, 0 -> the output sequence matches the model exactly; in_ready = 0 on every stalled cycle; table switches only at block boundaries; an in_tsel flip mid-block is ignored.
5. cfg_we asserted during a block -> cfg_err pulses 1 cycle and the table is unchanged (the next block still uses the old R). The same write issued with busy = 0 -> accepted and cfg_err = 0.
6. rst asserted after 30 coefficients -> on the next cycle out_valid = 0, busy = 0, tables are identity; a new block then starts at idx 0 and produces correct output.

Source files
------------

// File: rtl/jpeg_stream_quantizer.sv
// Coefficient-serial JPEG quantizer: per-position reciprocal multiply,
// round-half-up, saturate; runtime-programmable tables.
module jpeg_stream_quantizer #(
  parameter int IN_W       = 11,
  parameter int OUT_W      = 11,
  parameter int FRAC       = 12,
  parameter int R_W        = 13,
  parameter int NUM_TABLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_W-1:0]               in_data,
  input  logic [$clog2(NUM_TABLES)-1:0] in_tsel,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              out_data,
  output logic [5:0]                    out_idx,
  output logic                          out_last,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_TABLES)-1:0] cfg_table,
  input  logic [5:0]                    cfg_addr,
  input  logic [R_W-1:0]                cfg_data,
  output logic                          cfg_err,
  output logic                          busy
);

  localparam int TW = $clog2(NUM_TABLES);
  localparam int PW = IN_W + R_W + 1;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BLK  = 1'b1;
  localparam logic [R_W-1:0] R_ONE = R_W'(64'd1 << FRAC);
  localparam logic signed [PW:0] HALF = (PW+1)'(64'd1 << (FRAC-1));
  localparam logic signed [PW:0] SAT_MAX = (PW+1)'((64'd1 << (OUT_W-1)) - 64'd1);
  localparam logic signed [PW:0] SAT_MIN = -SAT_MAX - (PW+1)'(1);

  logic             state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic [TW-1:0]    tsel_q, tsel_d;
  logic [TW-1:0]    tsel_in, act_tsel;
  logic [R_W-1:0]   tbl_q [NUM_TABLES][64];
  logic [R_W-1:0]   tbl_d [NUM_TABLES][64];

  logic             s1_v_q, s1_v_d;
  logic [IN_W-1:0]  s1_data_q, s1_data_d;
  logic [5:0]       s1_idx_q, s1_idx_d;
  logic [R_W-1:0]   s1_r_q, s1_r_d;

  logic             s2_v_q, s2_v_d;
  logic [OUT_W-1:0] s2_data_q, s2_data_d;
  logic [5:0]       s2_idx_q, s2_idx_d;
  logic             s2_last_q, s2_last_d;
  logic             cfg_err_q, cfg_err_d;

  logic                 stall, acc, wr_ok;
  logic signed [PW-1:0] prod;
  logic signed [PW:0]   rnd, qv;
  logic [OUT_W-1:0]     sat;

  assign stall     = s2_v_q && !out_ready;
  assign in_ready  = !stall;
  assign acc       = in_valid && in_ready;
  assign busy      = (state_q == ST_BLK) || s1_v_q || s2_v_q;
  assign out_valid = s2_v_q;
  assign out_data  = s2_data_q;
  assign out_idx   = s2_idx_q;
  assign out_last  = s2_last_q;
  assign cfg_err   = cfg_err_q;

  // Table select is only honoured on the first coefficient of a block
  assign tsel_in  = (32'(in_tsel) >= NUM_TABLES) ? '0 : in_tsel;
  assign act_tsel = (state_q == ST_IDLE) ? tsel_in : tsel_q;

  assign prod = PW'($signed(s1_data_q)) * PW'($signed({1'b0, s1_r_q}));
  assign rnd  = (PW+1)'(prod) + HALF;
  assign qv   = rnd >>> FRAC;
  assign sat  = (qv > SAT_MAX) ? OUT_W'(SAT_MAX) :
                (qv < SAT_MIN) ? OUT_W'(SAT_MIN) : OUT_W'(qv);

  assign wr_ok = cfg_we && !busy && !in_valid &&
                 (32'(cfg_table) < NUM_TABLES);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tsel_d    = tsel_q;
    s1_v_d    = s1_v_q;
    s1_data_d = s1_data_q;
    s1_idx_d  = s1_idx_q;
    s1_r_d    = s1_r_q;
    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
    s2_idx_d  = s2_idx_q;
    s2_last_d = s2_last_q;
    cfg_err_d = cfg_we && !wr_ok;
    tbl_d     = tbl_q;
    if (acc) begin
      idx_d   = idx_q + 6'd1;
      state_d = (idx_d == 6'd0) ? ST_IDLE : ST_BLK;
      if (state_q == ST_IDLE) tsel_d = tsel_in;
    end
    // Both stages advance together; a stall freezes the whole pipe
    if (!stall) begin
      s1_v_d = acc;
      s2_v_d = s1_v_q;
      if (acc) begin
        s1_data_d = in_data;
        s1_idx_d  = idx_q;
        s1_r_d    = tbl_q[act_tsel][idx_q];
      end
      if (s1_v_q) begin
        s2_data_d = sat;
        s2_idx_d  = s1_idx_q;
        s2_last_d = (s1_idx_q == 6'd63);
      end
    end
    if (wr_ok) tbl_d[cfg_table][cfg_addr] = cfg_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      tsel_q    <= '0;
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s1_idx_q  <= '0;
      s1_r_q    <= '0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      s2_idx_q  <= '0;
      s2_last_q <= 1'b0;
      cfg_err_q <= 1'b0;
      for (int t = 0; t < NUM_TABLES; t++)
        for (int a = 0; a < 64; a++)
          tbl_q[t][a] <= R_ONE;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tsel_q    <= tsel_d;
      s1_v_q    <= s1_v_d;
      s1_data_q <= s1_data_d;
      s1_idx_q  <= s1_idx_d;
      s1_r_q    <= s1_r_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      s2_idx_q  <= s2_idx_d;
      s2_last_q <= s2_last_d;
      cfg_err_q <= cfg_err_d;
      tbl_q     <= tbl_d;
    end
  end

endmodule
